// File: rtl/code_receiver_pkg.sv
// -----------------------------------------------------------------------------
// code_receiver_pkg
// Shared definitions for the serial code receiver: FSM state encoding,
// default bit period and the frame-format constants.
// No ports (package).
// -----------------------------------------------------------------------------
package code_receiver_pkg;

   // 4 kHz bit rate at a 50 MHz system clock
   localparam int unsigned BIT_CYCLES_DEFAULT = 12500;

   // Frame format: idle low, start bit high, 8 data bits MSB first, stop low
   localparam logic        START_LVL = 1'b1;
   localparam logic        STOP_LVL  = 1'b0;
   localparam int unsigned DATA_BITS = 8;

   localparam int unsigned IDX_W   = $clog2(DATA_BITS);
   localparam int unsigned TIMER_W = 16;   // covers BIT_CYCLES up to 65535

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_e;

endpackage

// File: rtl/code_receiver_if.sv
// -----------------------------------------------------------------------------
// code_receiver_if
// Groups the serial line and the decoded-code outputs of code_receiver.
//   rx_in      : serial line from the transmitter board (asynchronous)
//   code       : last correctly framed byte
//   code_valid : one-cycle pulse when code updates
//   frame_err  : one-cycle pulse on a bad stop bit
//   busy       : high whenever the receiver is not idle
// Modports: master = line driver / code consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface code_receiver_if;
   import code_receiver_pkg::*;

   logic                 rx_in;
   logic [DATA_BITS-1:0] code;
   logic                 code_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output rx_in,
      input  code, code_valid, frame_err, busy
   );

   modport slave (
      input  rx_in,
      output code, code_valid, frame_err, busy
   );

endinterface

// File: rtl/code_receiver_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Free-running bit-period counter 0..BIT_CYCLES-1 with synchronous clear.
//   clk_i    : system clock (rising edge)
//   rst_ni   : asynchronous active-low reset
//   clr_i    : hold the count at 0
//   sample_o : strobe at the mid-bit sample point (count == BIT_CYCLES/2)
//   wrap_o   : strobe on the last count of a bit period
// -----------------------------------------------------------------------------
module bit_timer
   import code_receiver_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic sample_o,
   output logic wrap_o
);

   localparam logic [TIMER_W-1:0] CNT_LAST   = TIMER_W'(BIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] CNT_SAMPLE = TIMER_W'(BIT_CYCLES / 2);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + TIMER_W'(1);
      if (clr_i || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sample_o = (cnt_q == CNT_SAMPLE);
   assign wrap_o   = (cnt_q == CNT_LAST);

endmodule

// File: rtl/code_receiver.sv
// -----------------------------------------------------------------------------
// code_receiver
// Receives 10-bit serial frames (start high, 8 data bits MSB first, stop low)
// and presents the last good byte with a one-cycle valid pulse, or a
// one-cycle frame-error pulse when the stop bit is wrong.
//   CLOCK_50 : 50 MHz system clock (rising edge)
//   RESET_N  : asynchronous active-low reset
//   bus      : code_receiver_if.slave (rx_in, code, code_valid, frame_err, busy)
// -----------------------------------------------------------------------------
module code_receiver
   import code_receiver_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
   input  logic           CLOCK_50,
   input  logic           RESET_N,
   code_receiver_if.slave bus
);

   // Synchronizer and edge history
   logic sync1_q, rx_s_q, rx_prev_q;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] code_q, code_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic tmr_clr, tmr_sample, tmr_wrap, bit_tick;

   bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
      .clk_i    (CLOCK_50),
      .rst_ni   (RESET_N),
      .clr_i    (tmr_clr),
      .sample_o (tmr_sample),
      .wrap_o   (tmr_wrap)
   );

   // Sample and wrap never coincide for BIT_CYCLES >= 4; masking with wrap
   // keeps a too-small BIT_CYCLES from sampling on the period boundary.
   assign bit_tick = tmr_sample & ~tmr_wrap;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q   <= 1'b0;
         rx_s_q    <= 1'b0;
         rx_prev_q <= 1'b0;
      end else begin
         sync1_q   <= bus.rx_in;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      code_d  = code_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      tmr_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Timer held at 0 so the first START cycle begins the bit period
            tmr_clr = 1'b1;
            if (!rx_prev_q && rx_s_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               if (rx_s_q == START_LVL) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;   // start glitch, drop silently
               end
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shift_d = {shift_q[DATA_BITS-2:0], rx_s_q};
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               if (rx_s_q == STOP_LVL) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            // Line stuck high after a bad stop: wait for it to fall first
            if (!rx_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.code       = code_q;
   assign bus.code_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_code_receiver.sv
// -----------------------------------------------------------------------------
// tb_code_receiver
// Self-checking bench for code_receiver with BIT_CYCLES = 16. Frames are
// generated at the line level; a reference model predicts, per frame, either
// a code_valid pulse (cycle and byte) or a frame_err pulse (cycle) from the
// time the start bit was driven, and tracks the expected code output.
// -----------------------------------------------------------------------------
module tb_code_receiver;
   import code_receiver_pkg::*;

   localparam int BIT = 16;
   // From the cycle the start bit is driven to the cycle the pulse is seen:
   // 2 synchronizer flops, 1 cycle to leave IDLE, BIT/2 to the first sample,
   // 1 cycle to act on it, 9 more bit periods to the stop sample, then the
   // registered pulse appears one cycle later (counted in the +1 above).
   localparam int LAT = 2 + 1 + BIT / 2 + 1 + 9 * BIT;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   code_receiver_if bus ();

   code_receiver #(.BIT_CYCLES(BIT)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- observation ----------------
   int         obs_v_cyc[$];
   logic [7:0] obs_v_code[$];
   int         obs_e_cyc[$];
   int         x_cnt = 0, both_cnt = 0, rep_cnt = 0;
   bit         mon_en = 1'b0;
   logic       pv = 1'b0, pe = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if ($isunknown({bus.code, bus.code_valid, bus.frame_err, bus.busy}))
            x_cnt <= x_cnt + 1;
         if (bus.code_valid === 1'b1) begin
            obs_v_cyc.push_back(cyc);
            obs_v_code.push_back(bus.code);
         end
         if (bus.frame_err === 1'b1) obs_e_cyc.push_back(cyc);
         if (bus.code_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt <= both_cnt + 1;
         if ((bus.code_valid === 1'b1 && pv === 1'b1) || (bus.frame_err === 1'b1 && pe === 1'b1))
            rep_cnt <= rep_cnt + 1;
         pv <= bus.code_valid;
         pe <= bus.frame_err;
      end
   end

   // ---------------- reference model ----------------
   int         exp_v_cyc[$];
   logic [7:0] exp_v_code[$];
   int         exp_e_cyc[$];
   logic [7:0] ref_code = 8'h00;

   int n_checks = 0, n_errors = 0;
   bit async_mode = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Advance to the next rising edge, then move off the edge
   task automatic next_edge();
      int off;
      @(posedge clk);
      off = async_mode ? int'($urandom_range(1, 9)) : 1;
      #(off);
   endtask

   task automatic hold_bit(input logic v);
      bus.rx_in = v;
      repeat (BIT - 1) @(posedge clk);
      next_edge();
   endtask

   task automatic idle_low(input int n);
      bus.rx_in = 1'b0;
      repeat (n - 1) @(posedge clk);
      next_edge();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      int t0;
      t0 = cyc;
      hold_bit(START_LVL);
      for (int i = 7; i >= 0; i--) hold_bit(b[i]);
      hold_bit(stop);
      if (stop == STOP_LVL) begin
         exp_v_cyc.push_back(t0 + LAT);
         exp_v_code.push_back(b);
         ref_code = b;
      end else begin
         exp_e_cyc.push_back(t0 + LAT);
      end
   endtask

   task automatic compare_events(input string tag);
      int nv, ne;
      chk({tag, "_n_valid"}, obs_v_cyc.size(), exp_v_cyc.size());
      chk({tag, "_n_err"}, obs_e_cyc.size(), exp_e_cyc.size());
      nv = (obs_v_cyc.size() < exp_v_cyc.size()) ? obs_v_cyc.size() : exp_v_cyc.size();
      ne = (obs_e_cyc.size() < exp_e_cyc.size()) ? obs_e_cyc.size() : exp_e_cyc.size();
      for (int i = 0; i < nv; i++) begin
         chk({tag, "_valid_cycle"}, obs_v_cyc[i], exp_v_cyc[i]);
         chk({tag, "_valid_code"}, 32'(obs_v_code[i]), 32'(exp_v_code[i]));
      end
      for (int i = 0; i < ne; i++) chk({tag, "_err_cycle"}, obs_e_cyc[i], exp_e_cyc[i]);
      obs_v_cyc.delete(); obs_v_code.delete(); obs_e_cyc.delete();
      exp_v_cyc.delete(); exp_v_code.delete(); exp_e_cyc.delete();
   endtask

   task automatic chk_outputs(input string tag, input logic [7:0] c, input logic v,
                              input logic e, input logic bz);
      chk({tag, "_code"}, 32'(bus.code), 32'(c));
      chk({tag, "_code_valid"}, 32'(bus.code_valid), 32'(v));
      chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'(e));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(bz));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed cyc=%0d required finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      logic       stp;
      logic [7:0] partial;

      bus.rx_in = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      idle_low(5);

      // Basic frame
      send_frame(8'hA5, STOP_LVL);
      idle_low(BIT);
      compare_events("a5");
      chk("a5_code_out", 32'(bus.code), 32'h0000_00A5);
      chk("a5_busy", 32'(bus.busy), 32'd0);

      // Start glitch 3 cycles wide
      bus.rx_in = 1'b1;
      repeat (3) next_edge();
      chk("glitch_busy_high", 32'(bus.busy), 32'd1);
      idle_low(2 * BIT);
      compare_events("glitch");
      chk("glitch_code", 32'(bus.code), 32'(ref_code));
      chk("glitch_busy_low", 32'(bus.busy), 32'd0);

      // Bad stop bit; line stays high a further bit period
      send_frame(8'h3C, 1'b1);
      hold_bit(1'b1);
      chk("err_busy_while_high", 32'(bus.busy), 32'd1);
      idle_low(4);
      chk("err_busy_after_low", 32'(bus.busy), 32'd0);
      idle_low(BIT);
      compare_events("err3c");
      chk("err_code_kept", 32'(bus.code), 32'h0000_00A5);

      // Back-to-back frames
      send_frame(8'h81, STOP_LVL);
      send_frame(8'h7E, STOP_LVL);
      idle_low(BIT);
      compare_events("b2b");
      chk("b2b_code", 32'(bus.code), 32'h0000_007E);

      // Reset in the middle of data bit 4
      partial = 8'h96;
      hold_bit(START_LVL);
      for (int i = 7; i >= 4; i--) hold_bit(partial[i]);
      bus.rx_in = partial[3];
      repeat (BIT / 2) @(posedge clk);
      #3;
      rst_n     = 1'b0;
      bus.rx_in = 1'b0;
      ref_code  = 8'h00;
      #1;
      chk_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      idle_low(3 * BIT);
      compare_events("midreset_quiet");
      send_frame(8'h55, STOP_LVL);
      idle_low(BIT);
      compare_events("f55");
      chk("f55_code", 32'(bus.code), 32'h0000_0055);

      // Random frames with the line driven off the clock edge
      async_mode = 1'b1;
      next_edge();
      for (int k = 0; k < 8; k++) begin
         b   = 8'($urandom);
         stp = ($urandom_range(0, 3) == 0) ? 1'b1 : STOP_LVL;
         send_frame(b, stp);
         idle_low(int'($urandom_range(BIT, 2 * BIT)));
         compare_events("rnd");
         chk("rnd_code", 32'(bus.code), 32'(ref_code));
         chk("rnd_busy", 32'(bus.busy), 32'd0);
      end

      chk("no_x_on_outputs", x_cnt, 0);
      chk("valid_err_together", both_cnt, 0);
      chk("pulse_two_cycles", rep_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
